// File: rtl/frame_buffer_writer.sv
// Packs a frame-aligned RGB565 pixel stream to RGB444 and writes it to a BRAM port in raster order.
// Optional ping-pong banking via FB_DOUBLE_BUFFER_EN (adds wr_addr MSB = bank and disp_bank output).
module frame_buffer_writer #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19
) (
   input  logic              p_clock,
   input  logic              reset,
   input  logic              capture_en,
   input  logic [15:0]       pixel_data,
   input  logic              pixel_valid,
   input  logic              frame_done,
   input  logic              clear_err,
   output logic              wr_en,
`ifdef FB_DOUBLE_BUFFER_EN
   output logic [ADDR_W:0]   wr_addr,
   output logic              disp_bank,
`else
   output logic [ADDR_W-1:0] wr_addr,
`endif
   output logic [11:0]       wr_data,
   output logic              frame_ready,
   output logic [7:0]        frame_count,
   output logic              overflow,
   output logic              short_frame
);

   localparam int              FRAME_PIXELS_I = H_RES * V_RES;
   localparam logic [ADDR_W:0] FRAME_PIXELS   = FRAME_PIXELS_I[ADDR_W:0];

   typedef enum logic {
      ST_SYNC,
      ST_CAPTURE
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic              r_wr_en;
`ifdef FB_DOUBLE_BUFFER_EN
   logic [ADDR_W:0]   r_wr_addr;
   logic              r_bank;
   logic              r_disp_bank;
`else
   logic [ADDR_W-1:0] r_wr_addr;
`endif
   logic [11:0]       r_wr_data;
   logic              r_frame_ready;
   logic [7:0]        r_frame_count;
   logic              r_overflow;
   logic              r_short_frame;
   logic [ADDR_W:0]   r_pix_cnt;
   logic              r_ovf_frame;

   logic              w_in_capture;
   logic              w_sync_start;
   logic              w_pix_accept;
   logic              w_pix_excess;
   logic              w_frame_end;
   logic [ADDR_W:0]   w_cnt_eff;
   logic              w_good;
   logic              w_short;
   logic [11:0]       w_rgb444;
   logic              w_unused;

   always_ff @(posedge p_clock) begin
      if (reset) begin
         r_state <= ST_SYNC;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_SYNC:    if (frame_done && capture_en)  w_state_next = ST_CAPTURE;
         ST_CAPTURE: if (frame_done && !capture_en) w_state_next = ST_SYNC;
         default:    w_state_next = ST_SYNC;
      endcase
   end

   assign w_in_capture = (r_state == ST_CAPTURE);
   assign w_sync_start = (r_state == ST_SYNC) && frame_done && capture_en;
   assign w_pix_accept = w_in_capture && pixel_valid && (r_pix_cnt <  FRAME_PIXELS);
   assign w_pix_excess = w_in_capture && pixel_valid && (r_pix_cnt == FRAME_PIXELS);
   assign w_frame_end  = w_in_capture && frame_done;

   // A pixel arriving with frame_done belongs to the ending frame, so judge completion on the post-increment count.
   assign w_cnt_eff = r_pix_cnt + {{ADDR_W{1'b0}}, w_pix_accept};
   assign w_good    = w_frame_end && (w_cnt_eff == FRAME_PIXELS) && !(r_ovf_frame || w_pix_excess);
   assign w_short   = w_frame_end && (w_cnt_eff <  FRAME_PIXELS);

   assign w_rgb444  = {pixel_data[15:12], pixel_data[10:7], pixel_data[4:1]};
   assign w_unused  = &{1'b0, pixel_data[11], pixel_data[6:5], pixel_data[0]};

   always_ff @(posedge p_clock) begin
      if (reset) begin
         r_wr_en       <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_frame_ready <= 1'b0;
         r_frame_count <= '0;
         r_overflow    <= 1'b0;
         r_short_frame <= 1'b0;
         r_pix_cnt     <= '0;
         r_ovf_frame   <= 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
         r_bank        <= 1'b0;
         r_disp_bank   <= 1'b0;
`endif
      end else begin
         r_wr_en       <= w_pix_accept;
         r_frame_ready <= w_good;

         if (w_pix_accept) begin
`ifdef FB_DOUBLE_BUFFER_EN
            r_wr_addr <= {r_bank, r_pix_cnt[ADDR_W-1:0]};
`else
            r_wr_addr <= r_pix_cnt[ADDR_W-1:0];
`endif
            r_wr_data <= w_rgb444;
         end

         if (w_sync_start || w_frame_end) begin
            r_pix_cnt <= '0;
         end else if (w_pix_accept) begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
         end

         if (w_frame_end) begin
            r_ovf_frame <= 1'b0;
         end else if (w_pix_excess) begin
            r_ovf_frame <= 1'b1;
         end

         if (w_good) begin
            r_frame_count <= r_frame_count + 8'd1;
`ifdef FB_DOUBLE_BUFFER_EN
            r_bank      <= ~r_bank;
            r_disp_bank <= r_bank;
`endif
         end

         // Error set conditions take priority over a coincident clear.
         if (w_pix_excess) begin
            r_overflow <= 1'b1;
         end else if (clear_err) begin
            r_overflow <= 1'b0;
         end

         if (w_short) begin
            r_short_frame <= 1'b1;
         end else if (clear_err) begin
            r_short_frame <= 1'b0;
         end
      end
   end

   assign wr_en       = r_wr_en;
   assign wr_addr     = r_wr_addr;
   assign wr_data     = r_wr_data;
   assign frame_ready = r_frame_ready;
   assign frame_count = r_frame_count;
   assign overflow    = r_overflow;
   assign short_frame = r_short_frame;
`ifdef FB_DOUBLE_BUFFER_EN
   assign disp_bank   = r_disp_bank;
`endif

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer with a 4x2 frame; expected values are hand-computed constants.
module tb_frame_buffer_writer;

   localparam int H_RES  = 4;
   localparam int V_RES  = 2;
   localparam int ADDR_W = 3;

   logic              p_clock = 1'b0;
   logic              reset;
   logic              capture_en;
   logic [15:0]       pixel_data;
   logic              pixel_valid;
   logic              frame_done;
   logic              clear_err;
   logic              wr_en;
`ifdef FB_DOUBLE_BUFFER_EN
   logic [ADDR_W:0]   wr_addr;
   logic              disp_bank;
`else
   logic [ADDR_W-1:0] wr_addr;
`endif
   logic [11:0]       wr_data;
   logic              frame_ready;
   logic [7:0]        frame_count;
   logic              overflow;
   logic              short_frame;

   int checks   = 0;
   int failures = 0;

   logic [15:0] pix_vec [8] = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0,
                                16'h001F, 16'h1234, 16'hAAAA, 16'h5555};
   logic [11:0] exp_vec [8] = '{12'hFFF, 12'h000, 12'hF00, 12'h0F0,
                                12'h00F, 12'h14A, 12'hA55, 12'h5AA};

   frame_buffer_writer #(
      .H_RES (H_RES),
      .V_RES (V_RES),
      .ADDR_W(ADDR_W)
   ) dut (
      .p_clock    (p_clock),
      .reset      (reset),
      .capture_en (capture_en),
      .pixel_data (pixel_data),
      .pixel_valid(pixel_valid),
      .frame_done (frame_done),
      .clear_err  (clear_err),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
`ifdef FB_DOUBLE_BUFFER_EN
      .disp_bank  (disp_bank),
`endif
      .wr_data    (wr_data),
      .frame_ready(frame_ready),
      .frame_count(frame_count),
      .overflow   (overflow),
      .short_frame(short_frame)
   );

   always #5 p_clock = ~p_clock;

   task automatic tick();
      @(posedge p_clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".wr_en"},       32'(wr_en),       32'd0);
      chk({tag, ".wr_addr"},     32'(wr_addr),     32'd0);
      chk({tag, ".wr_data"},     32'(wr_data),     32'd0);
      chk({tag, ".frame_ready"}, 32'(frame_ready), 32'd0);
      chk({tag, ".frame_count"}, 32'(frame_count), 32'd0);
      chk({tag, ".overflow"},    32'(overflow),    32'd0);
      chk({tag, ".short_frame"}, 32'(short_frame), 32'd0);
   endtask

   task automatic pix(input logic [15:0] d);
      pixel_valid = 1'b1;
      pixel_data  = d;
      tick();
      pixel_valid = 1'b0;
   endtask

   task automatic pulse_frame_done();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
   endtask

   initial begin
      logic [ADDR_W-1:0] addr_lo;
      reset       = 1'b1;
      capture_en  = 1'b1;
      pixel_data  = '0;
      pixel_valid = 1'b0;
      frame_done  = 1'b0;
      clear_err   = 1'b0;
      tick();
      tick();
      chk_reset_state("reset");
      reset = 1'b0;

      // Initial sync: pixels before any frame_done are ignored
      for (int i = 0; i < 8; i++) begin
         pix(16'hFFFF);
         chk("sync.wr_en", 32'(wr_en), 32'd0);
         chk("sync.frame_ready", 32'(frame_ready), 32'd0);
      end

      // Good frame
      pulse_frame_done();
      chk("align.frame_ready", 32'(frame_ready), 32'd0);
      chk("align.wr_en", 32'(wr_en), 32'd0);
      for (int i = 0; i < 8; i++) begin
         pix(pix_vec[i]);
         addr_lo = wr_addr[ADDR_W-1:0];
         chk($sformatf("good.wr_en[%0d]", i), 32'(wr_en), 32'd1);
         chk($sformatf("good.wr_addr[%0d]", i), 32'(addr_lo), 32'(i));
         chk($sformatf("good.wr_data[%0d]", i), 32'(wr_data), 32'(exp_vec[i]));
      end
      tick();
      chk("good.idle_wr_en", 32'(wr_en), 32'd0);
      chk("good.hold_wr_data", 32'(wr_data), 32'h5AA);
      pulse_frame_done();
      chk("good.frame_ready", 32'(frame_ready), 32'd1);
      chk("good.frame_count", 32'(frame_count), 32'd1);
      chk("good.short_frame", 32'(short_frame), 32'd0);
      tick();
      chk("good.ready_one_cycle", 32'(frame_ready), 32'd0);

      // Short frame, then clear
      for (int i = 0; i < 5; i++) pix(16'h1234);
      pulse_frame_done();
      chk("short.short_frame", 32'(short_frame), 32'd1);
      chk("short.frame_ready", 32'(frame_ready), 32'd0);
      chk("short.frame_count", 32'(frame_count), 32'd1);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("short.cleared", 32'(short_frame), 32'd0);

      // Overlong frame: 10 pixels, only 8 written
      for (int i = 0; i < 10; i++) begin
         pix(pix_vec[i % 8]);
         addr_lo = wr_addr[ADDR_W-1:0];
         if (i < 8) begin
            chk($sformatf("over.wr_en[%0d]", i), 32'(wr_en), 32'd1);
            chk($sformatf("over.wr_addr[%0d]", i), 32'(addr_lo), 32'(i));
         end else begin
            chk($sformatf("over.no_write[%0d]", i), 32'(wr_en), 32'd0);
         end
         chk($sformatf("over.overflow[%0d]", i), 32'(overflow), (i >= 8) ? 32'd1 : 32'd0);
      end
      pulse_frame_done();
      chk("over.frame_ready", 32'(frame_ready), 32'd0);
      chk("over.frame_count", 32'(frame_count), 32'd1);
      chk("over.short_frame", 32'(short_frame), 32'd0);
      chk("over.overflow_sticky", 32'(overflow), 32'd1);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("over.cleared", 32'(overflow), 32'd0);

      // Last pixel coincident with frame_done
      for (int i = 0; i < 7; i++) pix(16'h07E0);
      pixel_valid = 1'b1;
      pixel_data  = 16'hF800;
      frame_done  = 1'b1;
      tick();
      pixel_valid = 1'b0;
      frame_done  = 1'b0;
      addr_lo = wr_addr[ADDR_W-1:0];
      chk("simul.wr_en", 32'(wr_en), 32'd1);
      chk("simul.wr_addr", 32'(addr_lo), 32'd7);
      chk("simul.wr_data", 32'(wr_data), 32'hF00);
      chk("simul.frame_ready", 32'(frame_ready), 32'd1);
      chk("simul.frame_count", 32'(frame_count), 32'd2);

      // Short-frame set wins over coincident clear_err
      for (int i = 0; i < 3; i++) pix(16'h001F);
      clear_err = 1'b1;
      pulse_frame_done();
      clear_err = 1'b0;
      chk("setwins.short_frame", 32'(short_frame), 32'd1);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("setwins.cleared", 32'(short_frame), 32'd0);

      // Synchronous reset mid-frame
      for (int i = 0; i < 3; i++) pix(16'hAAAA);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_reset_state("midreset");
      for (int i = 0; i < 8; i++) begin
         pix(16'h5555);
         chk("midreset.no_write", 32'(wr_en), 32'd0);
      end
      pulse_frame_done();
      chk("midreset.align_ready", 32'(frame_ready), 32'd0);
      for (int i = 0; i < 8; i++) begin
         pix(pix_vec[i]);
         addr_lo = wr_addr[ADDR_W-1:0];
         chk($sformatf("recap.wr_addr[%0d]", i), 32'(addr_lo), 32'(i));
         chk($sformatf("recap.wr_data[%0d]", i), 32'(wr_data), 32'(exp_vec[i]));
      end
      pulse_frame_done();
      chk("recap.frame_ready", 32'(frame_ready), 32'd1);
      chk("recap.frame_count", 32'(frame_count), 32'd1);

      // capture_en dropped mid-frame: frame still completes, next one is ignored
      for (int i = 0; i < 4; i++) pix(16'hFFFF);
      capture_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pix(16'h0000);
         chk("capoff.still_writing", 32'(wr_en), 32'd1);
      end
      pulse_frame_done();
      chk("capoff.frame_ready", 32'(frame_ready), 32'd1);
      chk("capoff.frame_count", 32'(frame_count), 32'd2);
      for (int i = 0; i < 8; i++) begin
         pix(16'hFFFF);
         chk("capoff.no_write", 32'(wr_en), 32'd0);
      end
      pulse_frame_done();
      chk("capoff.no_ready", 32'(frame_ready), 32'd0);
      pix(16'hFFFF);
      chk("capoff.still_sync", 32'(wr_en), 32'd0);
      chk("capoff.count_hold", 32'(frame_count), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
